// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ requesters, with burst lock.
// Optional macro ZERO_REG_DROP_EN: accepted beats addressed to register 0 are consumed without a write strobe.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            Req_Valid,
  output logic [NUM_REQ-1:0]            Req_Ready,
  input  logic [NUM_REQ-1:0]            Req_Lock,
  input  logic [NUM_REQ*ADDR_W-1:0]     Req_Addr,
  input  logic [NUM_REQ*DATA_W-1:0]     Req_Data,
  output logic [ADDR_W-1:0]             Select,
  output logic                          Wenable,
  output logic [DATA_W-1:0]             Write_Data,
  output logic [$clog2(NUM_REQ)-1:0]    Grant_Id,
  output logic                          Busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK) + 1;

  typedef enum logic {ARB, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rrPtr_q, rrPtr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]  lockCnt_q, lockCnt_d;
  logic [ADDR_W-1:0] select_q;
  logic [DATA_W-1:0] writeData_q;
  logic [ID_W-1:0]   grantId_q;
  logic              wen_q, wen_d;
  logic              busy_q;

  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              accept;
  logic              winLock;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winData;

  // While locked only the owner is eligible; otherwise search upward from the last winner.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    if (state_q == LOCKED) begin
      winner = owner_q;
      found  = Req_Valid[owner_q];
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = ID_W'((int'(rrPtr_q) + k) % NUM_REQ);
        if (!found && Req_Valid[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  assign accept  = found & ~Reset;
  assign winLock = Req_Lock[winner];
  assign winAddr = Req_Addr[int'(winner)*ADDR_W +: ADDR_W];
  assign winData = Req_Data[int'(winner)*DATA_W +: DATA_W];

  always_comb begin
    Req_Ready = '0;
    if (accept) Req_Ready[winner] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    owner_d   = owner_q;
    lockCnt_d = lockCnt_q;
    if (state_q == ARB) begin
      if (accept) begin
        rrPtr_d = winner;
        if (winLock) begin
          state_d   = LOCKED;
          owner_d   = winner;
          lockCnt_d = CNT_W'(1);
        end
      end
    end else begin
      // The MAX_LOCK-th beat releases the lock even if the owner still asks to keep it.
      if (accept && winLock && (lockCnt_q < CNT_W'(MAX_LOCK - 1))) begin
        lockCnt_d = lockCnt_q + 1'b1;
      end else begin
        state_d = ARB;
      end
    end
  end

`ifdef ZERO_REG_DROP_EN
  assign wen_d = accept && (winAddr != '0);
`else
  assign wen_d = accept;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ARB;
      rrPtr_q     <= ID_W'(NUM_REQ - 1);
      owner_q     <= '0;
      lockCnt_q   <= '0;
      select_q    <= '0;
      writeData_q <= '0;
      grantId_q   <= '0;
      wen_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      owner_q   <= owner_d;
      lockCnt_q <= lockCnt_d;
      wen_q     <= wen_d;
      busy_q    <= (state_d == LOCKED);
      if (accept) begin
        select_q    <= winAddr;
        writeData_q <= winData;
        grantId_q   <= winner;
      end
    end
  end

  assign Select     = select_q;
  assign Wenable    = wen_q;
  assign Write_Data = writeData_q;
  assign Grant_Id   = grantId_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table, zero-address beat, then
// randomized traffic compared against a lock-owner/beat-count reference model.
module tb_regfile_write_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int MAX_LOCK = 8;

  logic                      Clk = 1'b0;
  logic                      Reset;
  logic [NUM_REQ-1:0]        Req_Valid;
  logic [NUM_REQ-1:0]        Req_Ready;
  logic [NUM_REQ-1:0]        Req_Lock;
  logic [NUM_REQ*ADDR_W-1:0] Req_Addr;
  logic [NUM_REQ*DATA_W-1:0] Req_Data;
  logic [ADDR_W-1:0]         Select;
  logic                      Wenable;
  logic [DATA_W-1:0]         Write_Data;
  logic [1:0]                Grant_Id;
  logic                      Busy;

  regfile_write_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Lock(Req_Lock),
    .Req_Addr(Req_Addr), .Req_Data(Req_Data),
    .Select(Select), .Wenable(Wenable), .Write_Data(Write_Data),
    .Grant_Id(Grant_Id), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: who holds the lock (-1 = nobody), how many beats it has had, last winner.
  int          mOwner = -1;
  int          mBeats = 0;
  int          mPtr   = NUM_REQ - 1;
  logic [4:0]  eSel   = '0;
  logic        eWen   = 1'b0;
  logic [31:0] eData  = '0;
  logic [1:0]  eGid   = '0;
  logic        eBusy  = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] lock;
    logic [3:0] ready;
    logic       wen;
    logic [4:0] sel;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] modelReady();
    int j;
    if (Reset) return 4'b0000;
    if (mOwner >= 0) return Req_Valid[mOwner] ? 4'(1 << mOwner) : 4'b0000;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (mPtr + k) % NUM_REQ;
      if (Req_Valid[j]) return 4'(1 << j);
    end
    return 4'b0000;
  endfunction

  task automatic modelClock();
    logic [3:0] r;
    int g;
    r = modelReady();
    g = 0;
    if (Reset) begin
      mOwner = -1; mBeats = 0; mPtr = NUM_REQ - 1;
      eSel = '0; eWen = 1'b0; eData = '0; eGid = '0;
    end else if (r != 0) begin
      for (int i = 0; i < NUM_REQ; i++) if (r[i]) g = i;
      eSel  = Req_Addr[g*ADDR_W +: ADDR_W];
      eData = Req_Data[g*DATA_W +: DATA_W];
      eGid  = 2'(g);
`ifdef ZERO_REG_DROP_EN
      eWen  = (eSel != 0);
`else
      eWen  = 1'b1;
`endif
      mPtr = g;
      if (mOwner < 0) begin
        if (Req_Lock[g]) begin
          mOwner = g;
          mBeats = 1;
        end
      end else begin
        mBeats++;
        if (!Req_Lock[g] || mBeats >= MAX_LOCK) mOwner = -1;
      end
    end else begin
      eWen   = 1'b0;
      mOwner = -1;
    end
    eBusy = (mOwner >= 0);
  endtask

  // One clock: check Ready with inputs settled, advance the model at the edge, check registered outputs.
  task automatic applyStimulus(output logic [3:0] expReady);
    #1;
    expReady = modelReady();
    checkOutput("Req_Ready", 32'(Req_Ready), 32'(expReady));
    @(posedge Clk);
    modelClock();
    #1;
    checkOutput("Wenable", 32'(Wenable), 32'(eWen));
    checkOutput("Select", 32'(Select), 32'(eSel));
    checkOutput("Write_Data", Write_Data, eData);
    checkOutput("Grant_Id", 32'(Grant_Id), 32'(eGid));
    checkOutput("Busy", 32'(Busy), 32'(eBusy));
    @(negedge Clk);
  endtask

  function automatic void addVec(logic rst, logic [3:0] valid, logic [3:0] lock,
                                 logic [3:0] ready, logic wen, logic [4:0] sel, logic busy);
    vec_t v;
    v.rst = rst; v.valid = valid; v.lock = lock; v.ready = ready;
    v.wen = wen; v.sel = sel; v.busy = busy;
    tbl.push_back(v);
  endfunction

  logic [3:0] seen;
  logic [3:0] held;
  logic [3:0] expDrop;

  initial begin
    Reset     = 1'b1;
    Req_Valid = '0;
    Req_Lock  = '0;
    Req_Addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    Req_Data  = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};

    // Reset held with everyone requesting, then plain round robin.
    addVec(1, 4'b1111, 4'b0000, 4'b0000, 0, 5'd0, 0);
    addVec(1, 4'b1111, 4'b0000, 4'b0000, 0, 5'd0, 0);
    addVec(0, 4'b1111, 4'b0000, 4'b0001, 1, 5'd1, 0);
    addVec(0, 4'b1111, 4'b0000, 4'b0010, 1, 5'd2, 0);
    addVec(0, 4'b1111, 4'b0000, 4'b0100, 1, 5'd3, 0);
    addVec(0, 4'b1111, 4'b0000, 4'b1000, 1, 5'd4, 0);
    addVec(0, 4'b1111, 4'b0000, 4'b0001, 1, 5'd1, 0);
    // Req 2 locks for three beats then releases; req 0 waits.
    addVec(0, 4'b0101, 4'b0100, 4'b0100, 1, 5'd3, 1);
    addVec(0, 4'b0101, 4'b0100, 4'b0100, 1, 5'd3, 1);
    addVec(0, 4'b0101, 4'b0100, 4'b0100, 1, 5'd3, 1);
    addVec(0, 4'b0101, 4'b0000, 4'b0100, 1, 5'd3, 0);
    addVec(0, 4'b0101, 4'b0000, 4'b0001, 1, 5'd1, 0);
    // Req 1 holds lock forever: forced release after MAX_LOCK beats, then req 3.
    for (int i = 1; i <= MAX_LOCK; i++)
      addVec(0, 4'b1010, 4'b0010, 4'b0010, 1, 5'd2, (i < MAX_LOCK) ? 1'b1 : 1'b0);
    addVec(0, 4'b1010, 4'b0010, 4'b1000, 1, 5'd4, 0);
    // Reset while locked owner is accepting, then req 0 wins first.
    addVec(0, 4'b0010, 4'b0010, 4'b0010, 1, 5'd2, 1);
    addVec(1, 4'b0010, 4'b0010, 4'b0000, 0, 5'd0, 0);
    addVec(0, 4'b1111, 4'b0000, 4'b0001, 1, 5'd1, 0);
    // Idle cycle: strobe drops, write fields hold.
    addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 5'd1, 0);

    for (int t = 0; t < tbl.size(); t++) begin
      Reset     = tbl[t].rst;
      Req_Valid = tbl[t].valid;
      Req_Lock  = tbl[t].lock;
      #1;
      checkOutput("tbl_ready", 32'(Req_Ready), 32'(tbl[t].ready));
      applyStimulus(seen);
      checkOutput("tbl_wen", 32'(Wenable), 32'(tbl[t].wen));
      checkOutput("tbl_sel", 32'(Select), 32'(tbl[t].sel));
      checkOutput("tbl_busy", 32'(Busy), 32'(tbl[t].busy));
      if (tbl[t].sel != 0) begin
        checkOutput("tbl_gid", 32'(Grant_Id), 32'(tbl[t].sel) - 32'd1);
        checkOutput("tbl_data", Write_Data, 32'h1000_0000 + 32'(tbl[t].sel) - 32'd1);
      end
    end

    // Register-0 write from req 0.
    Req_Valid = 4'b0001;
    Req_Lock  = 4'b0000;
    Req_Addr[0 +: ADDR_W]   = 5'd0;
    Req_Data[0 +: DATA_W]   = 32'hDEAD_BEEF;
    applyStimulus(seen);
`ifdef ZERO_REG_DROP_EN
    expDrop = 4'b0000;
`else
    expDrop = 4'b0001;
`endif
    checkOutput("zero_wen", 32'(Wenable), 32'(expDrop[0]));
    checkOutput("zero_sel", 32'(Select), 32'd0);
    checkOutput("zero_data", Write_Data, 32'hDEAD_BEEF);
    checkOutput("zero_gid", 32'(Grant_Id), 32'd0);

    // Random traffic; a requester that was not accepted keeps its request stable.
    held = '0;
    for (int c = 0; c < 1500; c++) begin
      Reset = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!held[i]) begin
          Req_Valid[i] = ($urandom_range(0, 99) < 55);
          Req_Addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 31));
          Req_Data[i*DATA_W +: DATA_W] = $urandom;
        end
        Req_Lock[i] = ($urandom_range(0, 99) < 70);
      end
      applyStimulus(seen);
      held = Reset ? 4'b0000 : (Req_Valid & ~seen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
